// File: rtl/digit_glyph_renderer_if.sv
// Bundle of the timing, digit-load, glyph-ROM and pixel-output signals
// that connect the digit glyph renderer to its surroundings.
interface digit_glyph_renderer_if #(
  parameter int NUM_DIGITS = 4
);
  logic [9:0]              hCount;
  logic [9:0]              vCount;
  logic                    videoOn;
  logic                    hSyncIn;
  logic                    vSyncIn;
  logic [2*NUM_DIGITS-1:0] digitsIn;
  logic [NUM_DIGITS-1:0]   digitMaskIn;
  logic                    loadStrobe;
  logic [5:0]              romAddress;
  logic [7:0]              romData;
  logic [7:0]              rgbOut;
  logic                    hSyncOut;
  logic                    vSyncOut;
  logic                    videoOnOut;
  logic                    updatePending;

  modport master (
    output hCount, vCount, videoOn, hSyncIn, vSyncIn,
    output digitsIn, digitMaskIn, loadStrobe, romData,
    input  romAddress, rgbOut, hSyncOut, vSyncOut, videoOnOut, updatePending
  );

  modport slave (
    input  hCount, vCount, videoOn, hSyncIn, vSyncIn,
    input  digitsIn, digitMaskIn, loadStrobe, romData,
    output romAddress, rgbOut, hSyncOut, vSyncOut, videoOnOut, updatePending
  );
endinterface

// File: rtl/digit_glyph_renderer.sv
// Renders a row of scaled ROM digit glyphs as RGB332 pixels with a 3-stage
// pipeline; digit values are double-buffered and committed once per frame.
module digit_glyph_renderer #(
  parameter int         NUM_DIGITS = 4,
  parameter int         SCALE_LOG2 = 0,
  parameter logic [9:0] X0         = 10'd100,
  parameter logic [9:0] Y0         = 10'd50,
  parameter logic [9:0] V_COMMIT   = 10'd480,
  parameter logic [7:0] FG_COLOR   = 8'hFF,
  parameter logic [7:0] BG_COLOR   = 8'h03
) (
  input logic                   pixelClk,
  input logic                   reset,
  digit_glyph_renderer_if.slave bus
);
  localparam int         W     = NUM_DIGITS * (8 << SCALE_LOG2);
  localparam int         H     = 16 << SCALE_LOG2;
  localparam logic [10:0] X_END = 11'(int'(X0) + W);
  localparam logic [10:0] Y_END = 11'(int'(Y0) + H);

  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || SCALE_LOG2 < 0 || SCALE_LOG2 > 2 ||
        int'(X0) + W > 1024) begin : g_bad_params
      $error("digit_glyph_renderer: illegal parameter combination");
    end
  endgenerate

  logic [2*NUM_DIGITS-1:0] shadow_code_q, active_code_q;
  logic [NUM_DIGITS-1:0]   shadow_mask_q, active_mask_q;
  logic                    pending_q, pending_d;

  logic       commit, in_box;
  logic [9:0] x_off, y_off;
  logic [2:0] slot, col;
  logic [3:0] row;
  logic [1:0] slot_code [8];
  logic       slot_mask [8];

  logic [5:0] rom_address_q, rom_address_d;
  logic       s1_in_box_q, s1_mask_q, s1_von_q, s1_hs_q, s1_vs_q;
  logic [2:0] s1_col_q;
  logic       s2_in_box_q, s2_mask_q, s2_von_q, s2_hs_q, s2_vs_q;
  logic [2:0] s2_col_q;
  logic [7:0] rgb_q, rgb_d;
  logic       hs_q, vs_q, von_q;

  // Pad the slot lookup to 8 entries so out-of-field slot indices stay in range.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_slot
      if (gi < NUM_DIGITS) begin : g_used
        assign slot_code[gi] = active_code_q[2*gi +: 2];
        assign slot_mask[gi] = active_mask_q[gi];
      end else begin : g_unused
        assign slot_code[gi] = 2'b00;
        assign slot_mask[gi] = 1'b0;
      end
    end
  endgenerate

  assign x_off  = bus.hCount - X0;
  assign y_off  = bus.vCount - Y0;
  assign in_box = bus.videoOn &&
                  (bus.hCount >= X0) && ({1'b0, bus.hCount} < X_END) &&
                  (bus.vCount >= Y0) && ({1'b0, bus.vCount} < Y_END);
  assign slot   = 3'(x_off >> (3 + SCALE_LOG2));
  assign col    = 3'(x_off >> SCALE_LOG2);
  assign row    = 4'(y_off >> SCALE_LOG2);
  assign commit = (bus.hCount == 10'd0) && (bus.vCount == V_COMMIT);

  always_comb begin
    rom_address_d = in_box ? {slot_code[slot], row} : 6'h00;
    rgb_d         = 8'h00;
    if (s2_von_q) begin
      if (s2_in_box_q && s2_mask_q && bus.romData[3'd7 - s2_col_q]) rgb_d = FG_COLOR;
      else if (s2_in_box_q)                                          rgb_d = BG_COLOR;
    end
    // A load coinciding with the commit stays pending for the next frame.
    pending_d = pending_q;
    if (commit)              pending_d = bus.loadStrobe;
    else if (bus.loadStrobe) pending_d = 1'b1;
  end

  always_ff @(posedge pixelClk) begin
    if (reset) begin
      shadow_code_q <= '0;
      shadow_mask_q <= '0;
      active_code_q <= '0;
      active_mask_q <= '0;
      pending_q     <= 1'b0;
      rom_address_q <= 6'h00;
      s1_in_box_q   <= 1'b0;
      s1_mask_q     <= 1'b0;
      s1_von_q      <= 1'b0;
      s1_hs_q       <= 1'b1;
      s1_vs_q       <= 1'b1;
      s1_col_q      <= 3'd0;
      s2_in_box_q   <= 1'b0;
      s2_mask_q     <= 1'b0;
      s2_von_q      <= 1'b0;
      s2_hs_q       <= 1'b1;
      s2_vs_q       <= 1'b1;
      s2_col_q      <= 3'd0;
      rgb_q         <= 8'h00;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      von_q         <= 1'b0;
    end else begin
      if (bus.loadStrobe) begin
        shadow_code_q <= bus.digitsIn;
        shadow_mask_q <= bus.digitMaskIn;
      end
      if (commit) begin
        active_code_q <= shadow_code_q;
        active_mask_q <= shadow_mask_q;
      end
      pending_q     <= pending_d;
      rom_address_q <= rom_address_d;
      s1_in_box_q   <= in_box;
      s1_mask_q     <= slot_mask[slot];
      s1_von_q      <= bus.videoOn;
      s1_hs_q       <= bus.hSyncIn;
      s1_vs_q       <= bus.vSyncIn;
      s1_col_q      <= col;
      s2_in_box_q   <= s1_in_box_q;
      s2_mask_q     <= s1_mask_q;
      s2_von_q      <= s1_von_q;
      s2_hs_q       <= s1_hs_q;
      s2_vs_q       <= s1_vs_q;
      s2_col_q      <= s1_col_q;
      rgb_q         <= rgb_d;
      hs_q          <= s2_hs_q;
      vs_q          <= s2_vs_q;
      von_q         <= s2_von_q;
    end
  end

  assign bus.romAddress    = rom_address_q;
  assign bus.rgbOut        = rgb_q;
  assign bus.hSyncOut      = hs_q;
  assign bus.vSyncOut      = vs_q;
  assign bus.videoOnOut    = von_q;
  assign bus.updatePending = pending_q;
endmodule

// File: doc/digit_glyph_renderer.md
Name: digit_glyph_renderer

Overview:
- Pixel-pipeline stage directly upstream of the 4-glyph digit ROM. The ROM holds digits '1'..'4', 16 rows each; its address is {code[1:0], row[3:0]}, it returns one 8-bit row, and that row is registered with 1-cycle latency.
- This block takes the VGA timing counters and drives the ROM address. It consumes the returned row byte, serialises it into a NUM_DIGITS-wide scaled digit field, and emits RGB332 pixels.
- Sync and blank are delay-matched so they stay aligned with the pixels.
- Digit values load through a shadow register and are committed once per frame during vertical blanking, so the display never tears.

Parameters:
- NUM_DIGITS, 4, number of digit slots; 1..8.
- SCALE_LOG2, 0, glyph magnification as a log2 value; 0..2 (x1, x2, x4).
- X0, 10'd100, left pixel column of the digit field.
- Y0, 10'd50, top pixel row of the digit field.
- V_COMMIT, 10'd480, vCount line on which the shadow register is committed (commit happens at hCount==0 on that line).
- FG_COLOR, 8'hFF, RGB332 colour for set glyph bits.
- BG_COLOR, 8'h03, RGB332 colour for the field background and for masked slots.

Ports:
- pixelClk  in  1  pixel clock; every register is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- hCount  in  10  current pixel column from the timing generator.
- vCount  in  10  current line from the timing generator.
- videoOn  in  1  1 = visible area.
- hSyncIn  in  1  active-low horizontal sync from the timing generator.
- vSyncIn  in  1  active-low vertical sync from the timing generator.
- digitsIn  in  2*NUM_DIGITS  digit codes (0..3 display '1'..'4'); slot 0 is leftmost and uses bits [1:0].
- digitMaskIn  in  NUM_DIGITS  per-slot visibility; 1 = draw the slot.
- loadStrobe  in  1  single-cycle capture of digitsIn and digitMaskIn into the shadow register.
- romAddress  out  6  registered address to the glyph ROM.
- romData  in  8  glyph row returned by the ROM, valid 1 cycle after romAddress.
- rgbOut  out  8  registered RGB332 pixel.
- hSyncOut  out  1  hSyncIn delayed by 3 cycles.
- vSyncOut  out  1  vSyncIn delayed by 3 cycles.
- videoOnOut  out  1  videoOn delayed by 3 cycles.
- updatePending  out  1  shadow register holds values not yet committed.

Behaviour:
Geometry:
- s = SCALE_LOG2; field width W = NUM_DIGITS*8<<s; field height H = 16<<s.
- inBox = videoOn && hCount>=X0 && hCount<X0+W && vCount>=Y0 && vCount<Y0+H; all comparisons are unsigned 10-bit.
- xOff = hCount-X0 and yOff = vCount-Y0.
- slot = xOff>>(3+s); col = (xOff>>s)&7; row = (yOff>>s)&15.

Pipeline (inputs sampled at edge T):
- Stage 1 (edge T+1):
  - romAddress <= inBox ? {activeCode[slot], row} : 6'h00.
  - Register inBox, col, activeMask[slot], videoOn, hSyncIn and vSyncIn.
- Stage 2 (edge T+2): the ROM presents romData. Delay the stage-1 controls by one more stage.
- Stage 3 (edge T+3):
  - If !videoOn_d, rgbOut <= 0.
  - Else if inBox_d && mask_d && romData[7-col_d], rgbOut <= FG_COLOR.
  - Else if inBox_d, rgbOut <= BG_COLOR.
  - Else rgbOut <= 0.
  - Column 0 of a glyph is romData bit 7.
- Pixel latency is exactly 3 cycles. hSyncOut, vSyncOut and videoOnOut have the same 3-cycle latency.

Shadow and commit:
- loadStrobe=1: shadow <= {digitsIn, digitMaskIn}; updatePending <= 1.
- Commit cycle (hCount==0 && vCount==V_COMMIT): activeCode/activeMask <= shadow, using the shadow value before this edge.
  - updatePending <= loadStrobe, so a load on the commit cycle stays pending until the next frame.
  - A commit with updatePending=0 is harmless and re-commits the same values.
- The active register changes only at commit; it never changes mid-frame.

Reset:
- romAddress=0, rgbOut=0, videoOnOut=0, hSyncOut=1, vSyncOut=1, updatePending=0.
- Shadow and active registers go to 0, so all slots are masked and the field shows BG_COLOR.
- All pipeline stages are cleared. Reset mid-line discards in-flight pixels.
- The first valid output appears 3 cycles after reset deasserts.

Boundaries:
- The field must end at or before column 1023 (X0+W<=1024); this is a parameter-legality check.
- Digit codes are always valid because they are 2-bit.
- Behaviour is identical on the last column and last row of the field. hCount=X0+W and vCount=Y0+H are outside the field.

Test Plan:
- Reset held 2 cycles -> rgbOut=0, romAddress=0, hSyncOut=vSyncOut=1, videoOnOut=0, updatePending=0.
- Defaults: load digitsIn=8'b11_10_01_00 with mask 4'hF, run to commit, then drive vCount=50, hCount=104, videoOn=1 -> romAddress=6'h00 at T+1; with the ROM model, rgbOut=8'hFF at T+3 (row 0x0C, col 4 set); hCount=100 -> rgbOut=8'h03.
- SCALE_LOG2=1: vCount=Y0+3, hCount=X0+16 -> romAddress={2'b01,4'h1}=6'h11; hCount=X0+W -> rgbOut=0.
- Load during a visible frame -> updatePending=1 and the display is unchanged until hCount=0, vCount=480; then new glyphs show. A second load on the commit cycle -> updatePending stays 1.
- Mask 4'b1011 -> every pixel of slot 2 is 8'h03 (BG). videoOn=0 inside the field -> rgbOut=0. Toggle hSyncIn -> hSyncOut follows exactly 3 cycles later.
- Assert reset mid-line inside the field -> next edge rgbOut=0; no stale FG pixel appears after release.
